// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM state type and fetch constants for the instruction-fetch unit.
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    localparam int PC_INC = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: redirect, instruction-memory and decode handshake signals of the fetch unit.
interface ifetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc_plus4;
    logic              fetch_err;
    modport master (
        input  redirect_valid, redirect_pc, mem_ack, mem_rdata, if_ready,
        output mem_req, mem_addr, if_valid, if_pc, if_instr, if_pc_plus4, fetch_err
    );
    modport slave (
        output redirect_valid, redirect_pc, mem_ack, mem_rdata, if_ready,
        input  mem_req, mem_addr, if_valid, if_pc, if_instr, if_pc_plus4, fetch_err
    );
endinterface

// File: rtl/ifetch_skid_reg.sv
// ifetch_skid_reg: output register holding {pc, instr, pc+4} with a valid bit for decode.
module ifetch_skid_reg
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc4_o,
    output logic [DATA_W-1:0] instr_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q, pc4_q;
    logic [DATA_W-1:0] instr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= load_i | (valid_q & ~clr_i);
            if (load_i) begin
                pc_q    <= pc_i;
                pc4_q   <= pc_i + ADDR_W'(PC_INC);
                instr_q <= instr_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch sequencer owning the PC, memory req/ack and decode valid/ready handshakes.
// Optional fetch watchdog (sticky fetch_err, parks in IDLE) enabled by IFETCH_TIMEOUT_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                TMO_CYC  = 16
) (
    input logic           clk,
    input logic           reset,
    ifetch_unit_if.master bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, redir_pc;
    logic              flush_q, flush_d, bubble_q, bubble_d;
    logic              req, load, clr, park, unused_ok;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign park          = err_q;
    assign bus.fetch_err = err_q;
    assign unused_ok     = &{1'b0, bus.redirect_pc[1:0]};
`else
    assign park          = 1'b0;
    assign bus.fetch_err = 1'b0;
    assign unused_ok     = &{1'b0, bus.redirect_pc[1:0], TMO_CYC != 0};
`endif

    assign redir_pc     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    // bubble_q masks the request for the single cycle after a flushed read completes
    assign req          = (state_q == REQ) && !bubble_q;
    assign bus.mem_req  = req;
    assign bus.mem_addr = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        flush_d  = flush_q;
        bubble_d = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = park ? IDLE : REQ;
                if (bus.redirect_valid) pc_d = redir_pc;
            end
            REQ: begin
                if (!req) begin
                    if (bus.redirect_valid) pc_d = redir_pc;
                end else if (bus.mem_ack) begin
                    if (flush_q || bus.redirect_valid) begin
                        pc_d     = bus.redirect_valid ? redir_pc : pend_q;
                        flush_d  = 1'b0;
                        bubble_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(PC_INC);
                        state_d = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    flush_d = 1'b1;
                    pend_d  = redir_pc;
                end
`ifdef IFETCH_TIMEOUT_EN
                if (req) cnt_d = bus.mem_ack ? '0 : cnt_q + 1'b1;
                if (req && !bus.mem_ack && cnt_q == CW'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    flush_d = 1'b0;
                    state_d = IDLE;
                end
`endif
            end
            HOLD: begin
                clr     = bus.redirect_valid || bus.if_ready;
                state_d = clr ? REQ : HOLD;
                if (bus.redirect_valid) pc_d = redir_pc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            flush_q  <= 1'b0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            flush_q  <= flush_d;
            bubble_q <= bubble_d;
        end
    end

    ifetch_skid_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .clr_i   (clr),
        .pc_i    (pc_q),
        .instr_i (bus.mem_rdata),
        .valid_o (bus.if_valid),
        .pc_o    (bus.if_pc),
        .pc4_o   (bus.if_pc_plus4),
        .instr_o (bus.if_instr)
    );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a program-order fetch model.
module tb_ifetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0, n_fail = 0, n_acc = 0, lat = 0, lat_next = 0, starts2 = 0, gap = 0;
    logic [31:0] exp_req = 0, exp_acc = 0, exp2 = 32'hFFFF_FFFC, tgt = 0;
    logic [31:0] prev_pc = 0, prev_instr = 0, prev_addr = 0;
    logic ready = 0, redir = 0, req_prev = 0, req2_prev = 0, prev_stall = 0, prev_redir = 0;
    logic start_seen = 0;

    ifetch_unit_if bus ();
    ifetch_unit_if bus2 ();

    ifetch_unit dut (.clk(clk), .reset(reset), .bus(bus.master));
    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // second instance: memory acks in the first request cycle, decode always ready
    assign bus2.mem_ack        = bus2.mem_req;
    assign bus2.mem_rdata      = memf(bus2.mem_addr);
    assign bus2.if_ready       = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic start, ack;
        @(posedge clk);
        #1;
        start = bus.mem_req && !req_prev;
        if (start) begin
            chk("req_addr", bus.mem_addr, exp_req);
            exp_req += 32'd4;
            lat = lat_next;
        end
        if (bus.mem_req && req_prev) chk("addr_stable", bus.mem_addr, prev_addr);
        if (bus.if_valid) chk("no_req_in_hold", 32'(bus.mem_req), 32'd0);
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.if_valid), 32'd1);
            chk("stall_pc", bus.if_pc, prev_pc);
            chk("stall_instr", bus.if_instr, prev_instr);
        end
        if (prev_redir) chk("drop_valid", 32'(bus.if_valid), 32'd0);
        if (bus.if_valid && ready && !redir) begin
            chk("acc_pc", bus.if_pc, exp_acc);
            chk("acc_instr", bus.if_instr, memf(exp_acc));
            chk("acc_pc4", bus.if_pc_plus4, exp_acc + 32'd4);
            exp_acc += 32'd4;
            n_acc++;
        end
        if (bus2.mem_req && !req2_prev && starts2 < 2) begin
            chk("wrap_addr", bus2.mem_addr, exp2);
            chk("wrap_err", 32'(bus2.fetch_err), 32'd0);
            exp2 += 32'd4;
            starts2++;
        end
        if (bus2.if_valid && bus2.if_pc == 32'hFFFF_FFFC) chk("wrap_pc4", bus2.if_pc_plus4, 32'd0);
        ack = 1'b0;
        if (bus.mem_req) begin
            if (lat == 0) ack = 1'b1;
            else lat--;
        end
        bus.mem_ack        = ack;
        bus.mem_rdata      = ack ? memf(bus.mem_addr) : $urandom;
        bus.if_ready       = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        prev_stall = bus.if_valid && !ready && !redir;
        prev_pc    = bus.if_pc;
        prev_instr = bus.if_instr;
        prev_addr  = bus.mem_addr;
        prev_redir = redir;
        if (redir) begin
            exp_req = tgt & ~32'd3;
            exp_acc = tgt & ~32'd3;
        end
        req_prev   = bus.mem_req;
        req2_prev  = bus2.mem_req;
        start_seen = start;
    endtask

    task automatic do_reset(input logic rd, input logic [31:0] t);
        #3 reset = 1'b0;
        #1;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_pc", bus.if_pc, 32'd0);
        chk("rst_instr", bus.if_instr, 32'd0);
        chk("rst_err", 32'(bus.fetch_err), 32'd0);
        bus.mem_ack = 1'b0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.redirect_valid = rd;
        bus.redirect_pc = t;
        exp_req = rd ? (t & ~32'd3) : 32'd0;
        exp_acc = exp_req;
        exp2 = 32'hFFFF_FFFC;
        starts2 = 0;
        lat = 0;
        req_prev = 1'b0;
        req2_prev = 1'b0;
        prev_stall = 1'b0;
        prev_redir = rd;
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        do_reset(1'b0, 32'h0);
        // streaming with single-cycle acks and an always-ready decoder
        ready = 1'b1;
        lat_next = 0;
        n_acc = 0;
        repeat (20) cycle();
        chk("stream_acc", 32'(n_acc), 32'd10);
        chk("wrap_starts", 32'(starts2), 32'd2);
        // decode stall while an instruction is held
        ready = 1'b0;
        for (int k = 0; k < 40 && !bus.if_valid; k++) cycle();
        chk("t2_valid", 32'(bus.if_valid), 32'd1);
        repeat (5) cycle();
        ready = 1'b1;
        repeat (4) cycle();
        // redirect in HOLD with if_ready high the same cycle
        ready = 1'b0;
        for (int k = 0; k < 40 && !bus.if_valid; k++) cycle();
        chk("t4_valid", 32'(bus.if_valid), 32'd1);
        ready = 1'b1;
        redir = 1'b1;
        tgt = 32'h43;
        cycle();
        redir = 1'b0;
        repeat (10) cycle();
        // redirect while the read of 0x8 is outstanding
        do_reset(1'b0, 32'h0);
        ready = 1'b1;
        lat_next = 0;
        for (int k = 0; k < 20 && exp_req != 32'h8; k++) cycle();
        lat_next = 4;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (start_seen) break;
        end
        chk("t3_start", 32'(start_seen), 32'd1);
        lat_next = 0;
        redir = 1'b1;
        tgt = 32'h100;
        cycle();
        redir = 1'b0;
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            gap++;
            if (start_seen) break;
        end
        chk("flush_gap", 32'(gap), 32'd5);
        repeat (10) cycle();
        // randomized traffic
        n_acc = 0;
        repeat (800) begin
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            lat_next = $urandom_range(0, 3);
            cycle();
        end
        redir = 1'b0;
        chk("rand_progress", 32'(n_acc >= 40), 32'd1);
        // reset during an outstanding read, then redirect during IDLE
        ready = 1'b1;
        lat_next = 3;
        for (int k = 0; k < 40 && !bus.mem_req; k++) cycle();
        chk("midop_req", 32'(bus.mem_req), 32'd1);
        do_reset(1'b1, 32'h203);
        lat_next = 0;
        repeat (12) cycle();
`ifdef IFETCH_TIMEOUT_EN
        do_reset(1'b0, 32'h0);
        lat_next = 100000;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (start_seen) break;
        end
        chk("tmo_start", 32'(start_seen), 32'd1);
        for (int k = 1; k < 16; k++) begin
            cycle();
            chk("tmo_err_early", 32'(bus.fetch_err), 32'd0);
            chk("tmo_req_early", 32'(bus.mem_req), 32'd1);
        end
        cycle();
        chk("tmo_err", 32'(bus.fetch_err), 32'd1);
        chk("tmo_req", 32'(bus.mem_req), 32'd0);
        repeat (3) cycle();
        chk("tmo_err_sticky", 32'(bus.fetch_err), 32'd1);
        chk("tmo_parked", 32'(bus.mem_req), 32'd0);
        lat_next = 0;
        do_reset(1'b0, 32'h0);
        repeat (4) cycle();
`else
        chk("err_tied", 32'(bus.fetch_err), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
